// File: rtl/key_filter.sv
// key_filter: per-key 2-flop synchroniser and debounce FSM that gives a clean level and a press pulse.
// Auto-repeat of the press pulse while a key is held is built only when KEY_FILTER_REPEAT_EN is defined.

module key_filter_lane #(
    parameter int CNT_DB   = 800000
`ifdef KEY_FILTER_REPEAT_EN
    ,
    parameter int CNT_HOLD = 20000000,
    parameter int CNT_RPT  = 4000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_flag
);
    localparam int CNT_W = (CNT_DB > 1) ? $clog2(CNT_DB) : 1;

    typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_e;

    logic [1:0]       sync_q;
    logic             key_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, rpt_flag;
    logic             key_state_q, key_state_d;
    logic             key_flag_q, key_flag_d;

    assign key_s = sync_q[1];

    // Every transition leaves the counter at zero, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_s) state_d = FILT_DN;
            end
            FILT_DN: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(CNT_DB - 1)) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (key_s) state_d = FILT_UP;
            end
            FILT_UP: begin
                if (!key_s) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_W'(CNT_DB - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        key_state_d = (state_d == DOWN) || (state_d == FILT_UP);
        key_flag_d  = press_d | rpt_flag;
    end

`ifdef KEY_FILTER_REPEAT_EN
    localparam int RPT_MAX = (CNT_HOLD > CNT_RPT) ? CNT_HOLD : CNT_RPT;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             held_q, held_d;

    // Runs only while staying in DOWN; held_q marks the initial hold delay as spent.
    always_comb begin
        rpt_d    = '0;
        held_d   = 1'b0;
        rpt_flag = 1'b0;
        if (state_q == DOWN && !key_s) begin
            held_d = held_q;
            if (!held_q && rpt_q == RPT_W'(CNT_HOLD - 1)) begin
                rpt_flag = 1'b1;
                held_d   = 1'b1;
            end else if (held_q && rpt_q == RPT_W'(CNT_RPT - 1)) begin
                rpt_flag = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            rpt_q  <= rpt_d;
            held_q <= held_d;
        end
    end
`else
    assign rpt_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            key_flag_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_n};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            key_flag_q  <= key_flag_d;
        end
    end

    assign key_state = key_state_q;
    assign key_flag  = key_flag_q;
endmodule

module key_filter #(
    parameter int KEY_W    = 2,
    parameter int CNT_DB   = 800000,
    parameter int CNT_HOLD = 20000000,
    parameter int CNT_RPT  = 4000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_flag
);
    for (genvar i = 0; i < KEY_W; i++) begin : g_lane
        key_filter_lane #(
            .CNT_DB   (CNT_DB)
`ifdef KEY_FILTER_REPEAT_EN
            ,
            .CNT_HOLD (CNT_HOLD),
            .CNT_RPT  (CNT_RPT)
`endif
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n     (key[i]),
            .key_state (key_state[i]),
            .key_flag  (key_flag[i])
        );
    end

`ifndef KEY_FILTER_REPEAT_EN
    // Repeat timing is configuration-only in this build; nothing is generated from it.
    if (CNT_HOLD < 1 || CNT_RPT < 1) begin : g_repeat_cfg_unused
    end
`endif
endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: segment table, hand-written latency/bounce/reset sequences and a random run
// checked every cycle against a run-length model of the debounce rules.

module tb_key_filter;
    localparam int KEY_W    = 2;
    localparam int CNT_DB   = 10;
    localparam int CNT_HOLD = 50;
    localparam int CNT_RPT  = 20;
`ifdef KEY_FILTER_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif
    localparam int P100_FLAGS  = RPT ? 3 : 1;
    localparam int HOLD1_FLAGS = RPT ? 8 : 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [KEY_W-1:0] key   = '1;
    logic [KEY_W-1:0] key_state, key_flag;

    key_filter #(
        .KEY_W(KEY_W), .CNT_DB(CNT_DB), .CNT_HOLD(CNT_HOLD), .CNT_RPT(CNT_RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_state(key_state), .key_flag(key_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] key;
        int         len;
        int         f0;
        int         f1;
        logic [1:0] st;
    } seg_t;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // model: synchroniser image, accepted level, disagreeing-sample run, cycles spent held in DOWN
    logic [1:0] m_s1, m_s2, m_lvl, m_flag;
    int         m_run[2], m_age[2];

    int         nflag[2], first_flag[2], fall_edge[2], low_cnt[2], both_cnt;
    logic [1:0] prev_flag, prev_state, obs_state;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_lvl = 2'b00; m_flag = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0;
            m_age[i] = -1;
        end
    endtask

    // A level change is accepted after CNT_DB+1 consecutive synced samples that disagree with it.
    task automatic model_edge(input logic [1:0] k);
        for (int i = 0; i < 2; i++) begin
            logic pin, flip;
            pin = ~m_s2[i];
            flip = 1'b0;
            m_flag[i] = 1'b0;
            if (pin == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == CNT_DB + 1) begin
                    m_lvl[i] = pin;
                    m_run[i] = 0;
                    flip = 1'b1;
                    if (pin) begin
                        m_flag[i] = 1'b1;
                        m_age[i] = 0;
                    end
                end
            end
            if (RPT && !flip) begin
                if (m_lvl[i] && pin) begin
                    if (m_age[i] < 0) m_age[i] = 0;
                    else begin
                        m_age[i]++;
                        if (m_age[i] >= CNT_HOLD && (m_age[i] - CNT_HOLD) % CNT_RPT == 0)
                            m_flag[i] = 1'b1;
                    end
                end else m_age[i] = -1;
            end
        end
        m_s2 = m_s1;
        m_s1 = k;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            nflag[i] = 0; first_flag[i] = -1; fall_edge[i] = -1; low_cnt[i] = 0;
        end
        both_cnt = 0;
    endtask

    // Check outputs of the previous edge, then drive and clock one edge.
    task automatic step(input logic [1:0] k, input logic r);
        @(negedge clk);
        check("key_state", key_state, m_lvl);
        check("key_flag", key_flag, m_flag);
        check("flag_twice", key_flag & prev_flag, 2'b00);
        for (int i = 0; i < 2; i++) begin
            if (key_flag[i]) begin
                nflag[i]++;
                if (first_flag[i] < 0) first_flag[i] = cyc;
            end
            if (prev_state[i] && !key_state[i]) fall_edge[i] = cyc;
            if (!key_state[i]) low_cnt[i]++;
        end
        if (key_flag == 2'b11) both_cnt++;
        prev_flag = key_flag;
        prev_state = key_state;
        obs_state = key_state;
        key = k;
        rst_n = r;
        @(posedge clk);
        cyc++;
        if (r) model_edge(k);
        else model_reset();
    endtask

    initial begin
        seg_t       segs[9];
        int         c0, c1, lastf;
        logic       k0;
        logic [1:0] rk;
        int         rrun[2];

        model_reset();
        clear_obs();
        prev_flag = 2'b00; prev_state = 2'b00; obs_state = 2'b00;

        segs[0] = '{"idle",     2'b11,  20, 0, 0,           2'b00};
        segs[1] = '{"press0",   2'b10, 100, P100_FLAGS, 0,  2'b01};
        segs[2] = '{"release0", 2'b11,  30, 0, 0,           2'b00};
        segs[3] = '{"glitch1",  2'b01,   8, 0, 0,           2'b00};
        segs[4] = '{"idle2",    2'b11,  20, 0, 0,           2'b00};
        segs[5] = '{"both",     2'b00,  40, 1, 1,           2'b11};
        segs[6] = '{"release2", 2'b11,  30, 0, 0,           2'b00};
        segs[7] = '{"hold1",    2'b01, 200, 0, HOLD1_FLAGS, 2'b10};
        segs[8] = '{"release1", 2'b11,  30, 0, 0,           2'b00};

        // keys toggling under reset must not leak through
        for (int j = 0; j < 8; j++) step(2'(j), 1'b0);
        #1;
        check("rst_state", key_state, 2'b00);
        check("rst_flag", key_flag, 2'b00);
        repeat (5) step(2'b11, 1'b1);

        for (int s = 0; s < 9; s++) begin
            clear_obs();
            repeat (segs[s].len) step(segs[s].key, 1'b1);
            check_int({segs[s].name, "_flags0"}, nflag[0], segs[s].f0);
            check_int({segs[s].name, "_flags1"}, nflag[1], segs[s].f1);
            check({segs[s].name, "_state"}, obs_state, segs[s].st);
            if (s == 5) check_int("both_same_cycle", both_cnt, 1);
        end

        // clean press: flag and release exactly 2 + CNT_DB edges after the first sampling edge
        clear_obs();
        c0 = cyc + 1;
        repeat (100) step(2'b10, 1'b1);
        c1 = cyc + 1;
        repeat (30) step(2'b11, 1'b1);
        check_int("press_latency", first_flag[0], c0 + 12);
        check_int("press_count", nflag[0], P100_FLAGS);
        check_int("key1_quiet", nflag[1], 0);
        check_int("release_latency", fall_edge[0], c1 + 12);

        // press bounce: toggle every 3 cycles, then settle low
        clear_obs();
        lastf = -1;
        k0 = 1'b1;
        for (int j = 0; j < 80; j++) begin
            logic nk;
            nk = (j < 40) ? (((j / 3) % 2) != 0) : 1'b0;
            if (k0 && !nk) lastf = cyc + 1;
            k0 = nk;
            step({1'b1, nk}, 1'b1);
        end
        check_int("bounce_latency", first_flag[0], lastf + 12);
        check_int("bounce_count", nflag[0], 1);

        // release bounce: 5-cycle high glitches while held
        clear_obs();
        for (int g = 0; g < 40; g++) step(((g / 5) % 2 == 0) ? 2'b11 : 2'b10, 1'b1);
        check_int("rel_bounce_flags", nflag[0], 0);
        check_int("rel_bounce_state_low", low_cnt[0], 0);
        clear_obs();
        c1 = cyc + 1;
        repeat (30) step(2'b11, 1'b1);
        check_int("rel_bounce_release", fall_edge[0], c1 + 12);

        // reset in the middle of filtering; key still low when reset lifts
        clear_obs();
        repeat (8) step(2'b10, 1'b1);
        repeat (3) step(2'b10, 1'b0);
        c1 = cyc + 1;
        repeat (30) step(2'b10, 1'b1);
        check_int("rst_mid_latency", first_flag[0], c1 + 12);
        check_int("rst_mid_count", nflag[0], 1);
        repeat (30) step(2'b11, 1'b1);

        // random runs of mixed lengths with occasional resets
        rk = 2'b11;
        rrun[0] = 0;
        rrun[1] = 0;
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (rrun[i] == 0) begin
                    rk[i] = 1'($urandom_range(0, 1));
                    rrun[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 60))
                                                          : int'($urandom_range(1, 12));
                end else rrun[i]--;
            end
            step(rk, ($urandom_range(0, 499) != 0));
        end
        repeat (20) step(2'b11, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
